// File: rtl/quad_encoder_bcd_counter.sv
// Quadrature encoder decoder with glitch filtering, x1/x2/x4 resolution and a
// wrap/saturate BCD up/down counter, all clocked by clk_50mhz with a sample tick.
module quad_encoder_bcd_counter #(
  parameter int DIGITS     = 4,
  parameter int SAMPLE_DIV = 250,
  parameter int FILTER_LEN = 3
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_n,
  input  logic                  enc_a,
  input  logic                  enc_b,
  input  logic [1:0]            mode,
  input  logic                  wrap_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  step_pulse,
  output logic                  step_dir,
  output logic                  at_limit,
  output logic                  err_pulse
);

  localparam int W     = 4 * DIGITS;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    MODE_X1     = 2'b00,
    MODE_X2     = 2'b01,
    MODE_X4     = 2'b10,
    MODE_X1_ALT = 2'b11
  } mode_e;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (v[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = (v[4*d +: 4] > 4'd9) ? 4'd9 : v[4*d +: 4];
    end
    return r;
  endfunction

  logic             r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic [DIV_W-1:0] r_div;
  logic [FLT_W-1:0] r_prime_cnt;
  logic [FLT_W-1:0] r_agree [2];
  logic [1:0]       r_filt;
  logic [1:0]       r_prev;
  logic [W-1:0]     r_count;
  logic             r_step_pulse, r_step_dir, r_at_limit, r_err_pulse;

  logic             w_tick, w_primed;
  logic [1:0]       w_sync, w_diff;
  logic             w_decode, w_illegal, w_a_chg, w_dir_up, w_counts, w_step;
  logic [W-1:0]     w_count_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= enc_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= enc_b;
      r_b_sync <= r_b_meta;
    end
  end

  assign w_sync   = {r_a_sync, r_b_sync};
  assign w_tick   = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_primed = (r_prime_cnt == FLT_W'(FILTER_LEN));

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_prime_cnt <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick && !w_primed) r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  // During priming the filters follow the synced inputs so the held position is not a step.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < 2; i++) r_agree[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < 2; i++) begin
        if (!w_primed) begin
          r_filt[i]  <= w_sync[i];
          r_agree[i] <= '0;
        end else if (w_sync[i] != r_filt[i]) begin
          if (r_agree[i] == FLT_W'(FILTER_LEN - 1)) begin
            r_filt[i]  <= w_sync[i];
            r_agree[i] <= '0;
          end else begin
            r_agree[i] <= r_agree[i] + 1'b1;
          end
        end else begin
          r_agree[i] <= '0;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_diff    = r_filt ^ r_prev;
    w_decode  = w_primed && (w_diff != 2'b00);
    w_illegal = (w_diff == 2'b11);
    w_a_chg   = w_diff[1];
    // Up when the new A differs from B, or when B moves to match A.
    w_dir_up  = w_a_chg ? (r_filt[1] != r_filt[0]) : (r_filt[1] == r_filt[0]);
    w_counts  = 1'b0;
    case (mode_e'(mode))
      MODE_X4: w_counts = 1'b1;
      MODE_X2: w_counts = w_a_chg;
      default: w_counts = w_a_chg && r_filt[1];
    endcase
    w_step = w_decode && !w_illegal && w_counts;

    w_count_next = r_count;
    if (load) begin
      w_count_next = bcd_clamp(load_value);
    end else if (w_step) begin
      if (w_dir_up) begin
        w_count_next = (r_count == ALL_NINES && !wrap_en) ? r_count : bcd_inc(r_count);
      end else begin
        w_count_next = (r_count == '0 && !wrap_en) ? r_count : bcd_dec(r_count);
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= '0;
      r_count      <= '0;
      r_step_pulse <= 1'b0;
      r_step_dir   <= 1'b0;
      r_at_limit   <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      if (w_tick && !w_primed) r_prev <= w_sync;
      else if (w_decode)       r_prev <= r_filt;
      r_count      <= w_count_next;
      r_at_limit   <= (w_count_next == '0) || (w_count_next == ALL_NINES);
      r_step_pulse <= w_step && !load;
      if (w_step && !load) r_step_dir <= w_dir_up;
      r_err_pulse  <= w_decode && w_illegal;
    end
  end

  assign count      = r_count;
  assign step_pulse = r_step_pulse;
  assign step_dir   = r_step_dir;
  assign at_limit   = r_at_limit;
  assign err_pulse  = r_err_pulse;

endmodule

// File: tb/tb_quad_encoder_bcd_counter.sv
// Directed bench for quad_encoder_bcd_counter: resolution modes, BCD carry/borrow,
// wrap/saturate limits, glitch rejection, illegal transitions, load priority and reset.
module tb_quad_encoder_bcd_counter;

  logic        clk_50mhz = 1'b0;
  logic        rst_n;
  logic        enc_a, enc_b;
  logic [1:0]  mode;
  logic        wrap_en, load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        step_pulse, step_dir, at_limit, err_pulse;

  int n_vec  = 0;
  int n_miss = 0;
  int n_step_seen = 0;
  int n_err_seen  = 0;
  int s0, e0;

  quad_encoder_bcd_counter #(
    .DIGITS     (4),
    .SAMPLE_DIV (4),
    .FILTER_LEN (2)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .mode       (mode),
    .wrap_en    (wrap_en),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .at_limit   (at_limit),
    .err_pulse  (err_pulse)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Pulse-cycle tallies; the stimulus takes before/after differences.
  always @(negedge clk_50mhz) begin
    if (step_pulse === 1'b1) n_step_seen++;
    if (err_pulse === 1'b1)  n_err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic move(input logic a, input logic b);
    @(negedge clk_50mhz);
    enc_a = a;
    enc_b = b;
    repeat (16) @(negedge clk_50mhz);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk_50mhz);
    load_value = v;
    load       = 1'b1;
    @(negedge clk_50mhz);
    load = 1'b0;
    @(negedge clk_50mhz);
  endtask

  task automatic do_reset();
    @(negedge clk_50mhz);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    repeat (24) @(negedge clk_50mhz);
  endtask

  task automatic up_cycle();
    move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
    mode = 2'b10; wrap_en = 1'b1; load = 1'b0; load_value = 16'h0000;
    repeat (3) @(negedge clk_50mhz);
    check("rst_count",    32'(count),      32'h0);
    check("rst_step",     32'(step_pulse), 32'h0);
    check("rst_dir",      32'(step_dir),   32'h0);
    check("rst_at_limit", 32'(at_limit),   32'h0);
    check("rst_err",      32'(err_pulse),  32'h0);
    rst_n = 1'b1;
    repeat (24) @(negedge clk_50mhz);
    check("idle_at_limit", 32'(at_limit), 32'h1);
    check("idle_no_step",  32'(n_step_seen), 32'h0);

    // x4 up then reverse
    s0 = n_step_seen;
    up_cycle();
    check("x4_up_count", 32'(count), 32'h0004);
    check("x4_up_steps", 32'(n_step_seen - s0), 32'h4);
    check("x4_up_dir",   32'(step_dir), 32'h1);
    s0 = n_step_seen;
    move(1'b0, 1'b1);
    move(1'b1, 1'b1);
    move(1'b1, 1'b0);
    move(1'b0, 1'b0);
    check("x4_dn_count", 32'(count), 32'h0000);
    check("x4_dn_steps", 32'(n_step_seen - s0), 32'h4);
    check("x4_dn_dir",   32'(step_dir), 32'h0);

    // x2, x1, and mode 11 as x1
    do_reset();
    mode = 2'b01;
    s0 = n_step_seen;
    up_cycle();
    check("x2_count", 32'(count), 32'h0002);
    check("x2_steps", 32'(n_step_seen - s0), 32'h2);
    do_reset();
    mode = 2'b00;
    s0 = n_step_seen;
    up_cycle();
    check("x1_count", 32'(count), 32'h0001);
    check("x1_steps", 32'(n_step_seen - s0), 32'h1);
    mode = 2'b11;
    up_cycle();
    check("m11_count", 32'(count), 32'h0002);

    // BCD carry and borrow in x1
    mode = 2'b00;
    do_load(16'h0099);
    check("load_0099", 32'(count), 32'h0099);
    move(1'b1, 1'b0);
    check("carry_0100", 32'(count), 32'h0100);
    move(1'b0, 1'b0);
    check("x1_a_fall_none", 32'(count), 32'h0100);
    do_load(16'h1000);
    move(1'b0, 1'b1);
    move(1'b1, 1'b1);
    check("borrow_0999", 32'(count), 32'h0999);
    check("borrow_dir",  32'(step_dir), 32'h0);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);

    // Limits with wrap
    do_load(16'h9999);
    check("all9_at_limit", 32'(at_limit), 32'h1);
    move(1'b1, 1'b0);
    check("wrap_up", 32'(count), 32'h0000);
    move(1'b0, 1'b0);
    move(1'b0, 1'b1);
    move(1'b1, 1'b1);
    check("wrap_dn", 32'(count), 32'h9999);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);

    // Saturation
    wrap_en = 1'b0;
    s0 = n_step_seen;
    move(1'b1, 1'b0);
    check("sat_up_count",    32'(count), 32'h9999);
    check("sat_up_pulse",    32'(n_step_seen - s0), 32'h1);
    check("sat_up_at_limit", 32'(at_limit), 32'h1);
    check("sat_up_dir",      32'(step_dir), 32'h1);
    move(1'b0, 1'b0);
    do_load(16'h0000);
    move(1'b0, 1'b1);
    move(1'b1, 1'b1);
    check("sat_dn_count",    32'(count), 32'h0000);
    check("sat_dn_at_limit", 32'(at_limit), 32'h1);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);
    wrap_en = 1'b1;

    // Glitch rejection: one tick ignored, two ticks accepted
    do_load(16'h0500);
    s0 = n_step_seen;
    @(negedge clk_50mhz);
    enc_a = 1'b1;
    repeat (4) @(negedge clk_50mhz);
    enc_a = 1'b0;
    repeat (16) @(negedge clk_50mhz);
    check("glitch_steps", 32'(n_step_seen - s0), 32'h0);
    check("glitch_count", 32'(count), 32'h0500);
    enc_a = 1'b1;
    repeat (8) @(negedge clk_50mhz);
    enc_a = 1'b0;
    repeat (16) @(negedge clk_50mhz);
    check("two_tick_steps", 32'(n_step_seen - s0), 32'h1);
    check("two_tick_count", 32'(count), 32'h0501);

    // Illegal 00->11, then decode continues from 11
    mode = 2'b10;
    s0 = n_step_seen;
    e0 = n_err_seen;
    move(1'b1, 1'b1);
    check("illegal_err",   32'(n_err_seen - e0), 32'h1);
    check("illegal_count", 32'(count), 32'h0501);
    check("illegal_steps", 32'(n_step_seen - s0), 32'h0);
    move(1'b0, 1'b1);
    check("after_illegal_count", 32'(count), 32'h0502);
    check("after_illegal_dir",   32'(step_dir), 32'h1);
    move(1'b0, 1'b0);
    check("after_illegal_count2", 32'(count), 32'h0503);

    // Load held across a step: load wins and clamps the A nibble
    s0 = n_step_seen;
    @(negedge clk_50mhz);
    load_value = 16'h00A5;
    load       = 1'b1;
    enc_a      = 1'b1;
    repeat (16) @(negedge clk_50mhz);
    load = 1'b0;
    @(negedge clk_50mhz);
    check("load_step_count", 32'(count), 32'h0095);
    check("load_step_pulse", 32'(n_step_seen - s0), 32'h0);
    check("load_step_limit", 32'(at_limit), 32'h0);
    move(1'b0, 1'b0);
    check("post_load_down", 32'(count), 32'h0094);

    // Reset while the encoder sits at 11
    move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    check("pre_reset_count", 32'(count), 32'h0096);
    @(negedge clk_50mhz);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    check("mid_reset_count", 32'(count), 32'h0000);
    s0 = n_step_seen;
    e0 = n_err_seen;
    rst_n = 1'b1;
    repeat (30) @(negedge clk_50mhz);
    check("post_reset_count", 32'(count), 32'h0000);
    check("post_reset_steps", 32'(n_step_seen - s0), 32'h0);
    check("post_reset_errs",  32'(n_err_seen - e0), 32'h0);
    check("post_reset_limit", 32'(at_limit), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/quad_encoder_bcd_counter.md
Name: quad_encoder_bcd_counter

Overview:
Parametrised successor to the MK991 single-edge BCD counter. Decodes a mechanical quadrature encoder (A/B) into a signed step stream, with these additions:
- Selectable x1/x2/x4 resolution.
- Glitch filtering.
- Wrap or saturate limits.
- Synchronous preset.
- Configurable digit count.
Runs entirely in the clk_50mhz domain using a sample-enable tick, with no derived clock. Output feeds the BCD display/UI logic.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count range 0..(10^DIGITS - 1)
SAMPLE_DIV, 250, clk_50mhz cycles per input sample tick (>=2)
FILTER_LEN, 3, consecutive differing samples required to accept a new phase level (>=1)

Ports:
clk_50mhz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enc_a  in  1  encoder phase A, asynchronous
enc_b  in  1  encoder phase B, asynchronous
mode  in  2  00=x1, 01=x2, 10=x4, 11=treated as x1
wrap_en  in  1  1=wrap at limits, 0=saturate
load  in  1  synchronous preset strobe
load_value  in  4*DIGITS  BCD preset value
count  out  4*DIGITS  BCD count, digit 0 in [3:0]
step_pulse  out  1  one-cycle pulse per decoded step
step_dir  out  1  direction of last step, 1=up
at_limit  out  1  count is 0 or all-9s
err_pulse  out  1  one-cycle pulse on illegal transition

Behaviour:
- Reset: clk_50mhz is the clock; rst_n is the asynchronous, active-low reset. All outputs, the divider, filters and decode state are cleared to 0.
- Synchronisation: enc_a/enc_b each pass through a 2-flop synchroniser.
- Sample tick: the divider counts 0..SAMPLE_DIV-1 and asserts tick for one cycle at SAMPLE_DIV-1.
- Filter (per phase, evaluated on tick):
  - Synced value != filtered level: increment agreement counter; when it reaches FILTER_LEN, filtered level <= synced value and counter <= 0.
  - Synced value == filtered level: counter <= 0.
- Priming: for the first FILTER_LEN ticks after reset, filtered levels load directly from the synced inputs. No events are decoded during this window.
- Decode: on the cycle after any filtered level changes, compare prev (A,B) with cur (A,B), then prev <= cur.
- Up sequence: 00->10->11->01->00 (A rising while B=0 is up). Down is the reverse.
- Counting per mode:
  - x1: count only on A rising. 00->10 up, 01->11 down.
  - x2: count on any A edge. 00->10 and 11->01 up; 01->11 and 10->00 down.
  - x4: count every legal single-bit transition.
- Illegal transition (both bits change in one update): err_pulse=1 for one cycle; no step, count unchanged, prev <= cur.
- Step event timing: count, step_pulse and step_dir all update in the same cycle as the decode. Latency from filter acceptance to count update is 1 clk.
- BCD arithmetic: ripple carry/borrow across digits.
  - Up from all-9s: wrap_en=1 gives 0; wrap_en=0 holds all-9s.
  - Down from 0: wrap_en=1 gives all-9s; wrap_en=0 holds 0.
- Saturation: step_pulse and step_dir still assert when the count is held at a limit.
- at_limit: registered; reflects the current count (==0 or all-9s).
- load: count <= load_value on the next edge, taking priority over a simultaneous step (that step is dropped, no step_pulse). Any nibble >9 in load_value is clamped to 9.
- mode/wrap_en changes take effect at the next decode; no state is flushed.
- Reset asserted mid-rotation clears everything. After release, priming prevents a spurious step from the held encoder position.

Test Plan:
Bench uses SAMPLE_DIV=4, FILTER_LEN=2, DIGITS=4, phase levels held for >=12 clk each.
- Resolution: after reset, one full up cycle 00->10->11->01->00:
  - x4 -> count 0x0004, 4 step_pulses, step_dir=1.
  - x2 -> 0x0002.
  - x1 -> 0x0001.
  - Reverse sequence in x4 from 0x0004 -> 0x0000.
- BCD carry/borrow: load 0x0099, one x1 up step -> 0x0100. Load 0x1000, one down step -> 0x0999.
- Limits:
  - Load 0x9999, wrap_en=1, up step -> 0x0000; down step -> 0x9999.
  - wrap_en=0, up step at 0x9999 -> holds 0x9999, step_pulse=1, at_limit=1.
- Glitch rejection: A high for only 1 sample tick -> no step_pulse, count unchanged. Held for 2 ticks -> step accepted.
- Illegal transition: filtered 00->11 in one update -> err_pulse for exactly 1 cycle, count unchanged. Next legal transition decodes from 11.
- Load and reset:
  - load asserted in the step cycle with load_value=0x00A5 -> count 0x0095, no step_pulse.
  - rst_n pulsed low while A=B=1 held -> count 0x0000; no step after release and priming.
